mac_dot_engine: RTL and testbench
=================================

Name: mac_dot_engine

Overview:
- Parametrised, pipelined multiply-accumulate engine that computes an N-term dot product sum(a[i]*b[i]) per transaction.
- Successor to the single-register MAC. Adds:
  - signed/unsigned mode
  - a programmable term count
  - guard-bit accumulator
  - valid/ready handshakes on input and result
  - sticky overflow detection
- Sits between a stream source (FIR taps, matrix row feeder) and a result consumer.

Parameters:
- WIDTH, 8, operand width of a and b.
- ACC_WIDTH, 2*WIDTH+8, accumulator/result width; must be >= 2*WIDTH (elaboration error otherwise).
- LEN_W, 8, width of the term-count field; max terms per transaction is 2**LEN_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin transaction; sampled only in IDLE
- len  input  LEN_W  number of terms; latched on accepted start
- signed_mode  input  1  1 = two's-complement operands; latched on accepted start
- in_valid  input  1  operand pair valid
- in_ready  output  1  engine accepts operand pair
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_acc  output  ACC_WIDTH  dot-product result
- busy  output  1  state != IDLE
- overflow  output  1  sticky per transaction; accumulator exceeded ACC_WIDTH range

Behaviour:
- Reset (async, active-high): state = IDLE; acc, product register, counter, overflow, out_valid, in_ready, busy all 0; out_acc = 0.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - in_ready = 0.
  - start && len != 0: latch len into remaining counter, latch signed_mode, clear acc and overflow, go to ACCUM.
  - start && len == 0: clear acc and overflow, go directly to DONE (result 0).
- ACCUM:
  - in_ready = 1.
  - Beat accepted on an edge with in_valid && in_ready.
  - Each accepted beat: product register <= a*b, full 2*WIDTH width, signed or unsigned per latched mode; product-valid flag set; counter decrements.
  - Bubbles (in_valid = 0) stall without effect.
  - The edge that accepts the last beat (counter == 1) moves to DRAIN.
- DRAIN:
  - in_ready = 0.
  - One cycle only, to add the final product; then go to DONE.
- Accumulate stage:
  - On any edge where product-valid is set: acc <= acc + extend(product), where extend is sign- or zero-extension to ACC_WIDTH per mode.
  - Product-valid clears when no beat is accepted that edge.
- Latency: last beat accepted at edge k; acc includes it after edge k+1; out_valid is high in the cycle following edge k+1.
- DONE:
  - out_valid = 1; out_acc = acc, held stable.
  - On an edge with out_ready: go to IDLE, out_valid drops.
  - The next start is sampled no earlier than the cycle after returning to IDLE.
- start outside IDLE is ignored. a/b/in_valid outside ACCUM are ignored.
- Overflow:
  - Unsigned: carry out of ACC_WIDTH.
  - Signed: sum of same-sign operands yields opposite sign.
  - Sets overflow (sticky until the next accepted start).
  - Overflow is only updated on accumulate edges.
- Reset mid-transaction: everything returns to reset values immediately; the partial sum is discarded.

Optional Feature:
- Macro: MAC_SATURATE_EN.
- Defined: on overflow the accumulator clamps and holds at the bound.
  - Unsigned: 2**ACC_WIDTH-1.
  - Signed: max positive, or min negative, per overflow direction.
  - Further terms keep the clamp unless they move the value back in range; the sum is computed from the clamped value.
  - overflow is still flagged.
- Not defined: the accumulator wraps modulo 2**ACC_WIDTH; overflow is flagged.

Test Plan:
- Unsigned, WIDTH=8, ACC_WIDTH=24, len=4, a={1,2,3,4}, b={5,6,7,8}, in_valid continuous -> out_acc=70, out_valid exactly 2 cycles after last accept, overflow=0.
- Signed, len=3, a={-2,127,-128}, b={3,-1,-128} -> out_acc=16251, overflow=0; same operands unsigned -> out_acc=254*3+127*255+128*128=49531.
- start with len=0 -> next cycle DONE, out_valid=1, out_acc=0, in_ready never asserted.
- len=3 with in_valid gaps of 2 cycles between beats; out_ready held low 5 cycles -> out_acc stable, in_ready=0, start pulses ignored, busy=1; out_ready=1 -> IDLE next cycle.
- ACC_WIDTH=16, unsigned, len=2, a=b=255 twice -> overflow=1; out_acc=64514 without MAC_SATURATE_EN, 65535 with it.
- Assert rst for 1 cycle mid-ACCUM after 2 of 4 beats -> all outputs 0, IDLE; new len=1 transaction a=3, b=4 -> out_acc=12.

Source files
------------

// File: rtl/mac_dot_engine_if.sv
// Operand/result handshake bundle for mac_dot_engine.
// master = stream source and result consumer; slave = the engine.
interface mac_dot_engine_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 2*WIDTH+8,
  parameter int unsigned LEN_W     = 8
);
  logic                 start;
  logic [LEN_W-1:0]     len;
  logic                 signed_mode;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_acc;
  logic                 busy;
  logic                 overflow;

  modport master (
    output start, len, signed_mode, in_valid, a, b, out_ready,
    input  in_ready, out_valid, out_acc, busy, overflow
  );

  modport slave (
    input  start, len, signed_mode, in_valid, a, b, out_ready,
    output in_ready, out_valid, out_acc, busy, overflow
  );
endinterface

// File: rtl/mac_dot_engine.sv
// Pipelined N-term dot-product MAC with guard-bit accumulator and sticky overflow.
// Define MAC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module mac_dot_engine #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 2*WIDTH+8,
  parameter int unsigned LEN_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  mac_dot_engine_if.slave  bus_io
);

  localparam int unsigned PW = 2*WIDTH;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  if (ACC_WIDTH < 2*WIDTH) begin : g_acc_width_check
    $error("mac_dot_engine: ACC_WIDTH must be >= 2*WIDTH");
  end

  logic [1:0]           state_q, state_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic [PW-1:0]        prod_q, prod_d;
  logic                 pvld_q, pvld_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;

  logic                 accept;
  logic [PW-1:0]        prod_u, prod_s;
  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH:0]   sum;
  logic                 add_ovf;
  logic [ACC_WIDTH-1:0] acc_next;

  assign accept = (state_q == StAccum) && bus_io.in_valid;

  // Operands widened to the product width first so the low PW bits are exact.
  always_comb begin
    prod_u = {{WIDTH{1'b0}}, bus_io.a} * {{WIDTH{1'b0}}, bus_io.b};
    prod_s = $signed({{WIDTH{bus_io.a[WIDTH-1]}}, bus_io.a})
           * $signed({{WIDTH{bus_io.b[WIDTH-1]}}, bus_io.b});
  end

  always_comb begin
    if (mode_q) begin
      ext = ACC_WIDTH'($signed(prod_q));
    end else begin
      ext = ACC_WIDTH'(prod_q);
    end
    sum = {1'b0, acc_q} + {1'b0, ext};
    if (mode_q) begin
      add_ovf = (acc_q[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    end else begin
      add_ovf = sum[ACC_WIDTH];
    end
`ifdef MAC_SATURATE_EN
    if (!add_ovf) begin
      acc_next = sum[ACC_WIDTH-1:0];
    end else if (!mode_q) begin
      acc_next = '1;
    end else if (acc_q[ACC_WIDTH-1]) begin
      // Both addends negative: clamp to the most negative value.
      acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    end else begin
      acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
`else
    acc_next = sum[ACC_WIDTH-1:0];
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    prod_d  = prod_q;
    pvld_d  = 1'b0;
    acc_d   = acc_q;
    ovf_d   = ovf_q;

    if (pvld_q) begin
      acc_d = acc_next;
      ovf_d = ovf_q | add_ovf;
    end

    if (accept) begin
      prod_d = mode_q ? prod_s : prod_u;
      pvld_d = 1'b1;
      cnt_d  = cnt_q - 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (bus_io.len != '0) begin
            cnt_d   = bus_io.len;
            mode_d  = bus_io.signed_mode;
            state_d = StAccum;
          end else begin
            state_d = StDone;
          end
        end
      end
      StAccum: begin
        if (accept && (cnt_q == LEN_W'(1))) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StDone;
      end
      StDone: begin
        if (bus_io.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      prod_q  <= '0;
      pvld_q  <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      prod_q  <= prod_d;
      pvld_q  <= pvld_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus_io.in_ready  = (state_q == StAccum);
  assign bus_io.out_valid = (state_q == StDone);
  assign bus_io.out_acc   = acc_q;
  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.overflow  = ovf_q;

endmodule

// File: tb/tb_mac_dot_engine.sv
// Self-checking bench: two engines (ACC_WIDTH 24 and 16) run in lockstep on the same
// stimulus and are compared against an arithmetic reference model.
module tb_mac_dot_engine;

`ifdef MAC_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start, signed_mode, in_valid, out_ready;
  logic [7:0] len, a, b;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [7:0] opa [0:15];
  logic [7:0] opb [0:15];

  always #5 clk = ~clk;

  mac_dot_engine_if #(.WIDTH(8), .ACC_WIDTH(24), .LEN_W(8)) if24 ();
  mac_dot_engine_if #(.WIDTH(8), .ACC_WIDTH(16), .LEN_W(8)) if16 ();

  assign if24.start       = start;
  assign if24.len         = len;
  assign if24.signed_mode = signed_mode;
  assign if24.in_valid    = in_valid;
  assign if24.a           = a;
  assign if24.b           = b;
  assign if24.out_ready   = out_ready;
  assign if16.start       = start;
  assign if16.len         = len;
  assign if16.signed_mode = signed_mode;
  assign if16.in_valid    = in_valid;
  assign if16.a           = a;
  assign if16.b           = b;
  assign if16.out_ready   = out_ready;

  mac_dot_engine #(.WIDTH(8), .ACC_WIDTH(24), .LEN_W(8)) dut24 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (if24)
  );

  mac_dot_engine #(.WIDTH(8), .ACC_WIDTH(16), .LEN_W(8)) dut16 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (if16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Term-by-term true arithmetic, then range check: wrap or clamp into aw bits.
  function automatic void model(input int aw, input bit sm, input int n,
                                output logic [63:0] res, output logic ovf);
    longint acc, p, s, modv, maxv, minv;
    acc  = 0;
    ovf  = 1'b0;
    modv = longint'(1) << aw;
    maxv = modv / 2 - 1;
    minv = -(modv / 2);
    for (int i = 0; i < n; i++) begin
      if (sm) p = longint'($signed(opa[i])) * longint'($signed(opb[i]));
      else    p = longint'(opa[i]) * longint'(opb[i]);
      s = acc + p;
      if (sm) begin
        if (s > maxv) begin
          ovf = 1'b1;
          s   = Sat ? maxv : s - modv;
        end else if (s < minv) begin
          ovf = 1'b1;
          s   = Sat ? minv : s + modv;
        end
      end else if (s > modv - 1) begin
        ovf = 1'b1;
        s   = Sat ? modv - 1 : s - modv;
      end
      acc = s;
    end
    res = 64'(acc & (modv - 1));
  endfunction

  task automatic check_result(input logic [63:0] e24, input logic e24o,
                              input logic [63:0] e16, input logic e16o);
    check("out_valid24", 64'(if24.out_valid), 64'(1));
    check("out_valid16", 64'(if16.out_valid), 64'(1));
    check("out_acc24",   64'(if24.out_acc),   e24);
    check("out_acc16",   64'(if16.out_acc),   e16);
    check("overflow24",  64'(if24.overflow),  64'(e24o));
    check("overflow16",  64'(if16.overflow),  64'(e16o));
  endtask

  // Called just after a rising edge with the engines in IDLE; returns the same way.
  task automatic run_txn(input int n, input bit sm, input int gap, input int hold);
    logic [63:0] e24, e16;
    logic        o24, o16;
    model(24, sm, n, e24, o24);
    model(16, sm, n, e16, o16);

    start       = 1'b1;
    len         = 8'(n);
    signed_mode = sm;
    in_valid    = 1'b1;          // must be ignored while IDLE
    a           = 8'($urandom);
    b           = 8'($urandom);
    @(posedge clk); #1;
    start       = 1'b0;
    signed_mode = !sm;           // mode must already be latched

    if (n == 0) begin
      in_valid = 1'b0;
      check("len0_in_ready", 64'(if24.in_ready), 64'(0));
    end else begin
      for (int i = 0; i < n; i++) begin
        check("in_ready_accum", 64'(if24.in_ready), 64'(1));
        in_valid = 1'b1;
        a        = opa[i];
        b        = opb[i];
        @(posedge clk); #1;
        if (i < n - 1) begin
          for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            a        = 8'($urandom);
            b        = 8'($urandom);
            @(posedge clk); #1;
          end
        end
      end
      // DRAIN: a stray beat here must not be taken.
      in_valid = 1'b1;
      a        = 8'($urandom);
      b        = 8'($urandom);
      check("drain_in_ready",  64'(if16.in_ready),  64'(0));
      check("drain_out_valid", 64'(if16.out_valid), 64'(0));
      check("drain_busy",      64'(if24.busy),      64'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    check_result(e24, o24, e16, o16);

    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start     = 1'b1;
      len       = 8'd5;
      @(posedge clk); #1;
      check("hold_out_acc24", 64'(if24.out_acc),   e24);
      check("hold_out_acc16", 64'(if16.out_acc),   e16);
      check("hold_out_valid", 64'(if24.out_valid), 64'(1));
      check("hold_in_ready",  64'(if24.in_ready),  64'(0));
      check("hold_busy",      64'(if16.busy),      64'(1));
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_out_valid", 64'(if24.out_valid), 64'(0));
    check("idle_busy",      64'(if16.busy),      64'(0));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, 64'(if24.out_valid | if16.out_valid), 64'(0));
    check({tag, "_in_ready"},  64'(if24.in_ready | if16.in_ready),   64'(0));
    check({tag, "_busy"},      64'(if24.busy | if16.busy),           64'(0));
    check({tag, "_overflow"},  64'(if24.overflow | if16.overflow),   64'(0));
    check({tag, "_out_acc24"}, 64'(if24.out_acc),                    64'(0));
    check({tag, "_out_acc16"}, 64'(if16.out_acc),                    64'(0));
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    len         = 8'd0;
    signed_mode = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    a           = 8'd0;
    b           = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Unsigned {1,2,3,4}.{5,6,7,8} = 70
    for (int i = 0; i < 4; i++) begin
      opa[i] = 8'(i + 1);
      opb[i] = 8'(i + 5);
    end
    run_txn(4, 1'b0, 0, 0);

    // {-2,127,-128}.{3,-1,-128}: signed 16251, unsigned 49531
    opa[0] = 8'hFE; opa[1] = 8'd127; opa[2] = 8'h80;
    opb[0] = 8'd3;  opb[1] = 8'hFF;  opb[2] = 8'h80;
    run_txn(3, 1'b1, 0, 0);
    run_txn(3, 1'b0, 0, 0);

    // Zero-length transaction goes straight to DONE with result 0
    run_txn(0, 1'b0, 0, 1);

    // Bubbles between beats and a stalled consumer
    for (int i = 0; i < 3; i++) begin
      opa[i] = 8'($urandom);
      opb[i] = 8'($urandom);
    end
    run_txn(3, 1'b0, 2, 5);

    // 255*255 twice: overflows the 16-bit accumulator only
    opa[0] = 8'hFF; opa[1] = 8'hFF;
    opb[0] = 8'hFF; opb[1] = 8'hFF;
    run_txn(2, 1'b0, 0, 0);

    // Signed positive overflow then signed negative overflow on the 16-bit engine
    for (int i = 0; i < 3; i++) begin
      opa[i] = 8'h80;
      opb[i] = 8'h80;
    end
    run_txn(3, 1'b1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      opa[i] = 8'd127;
      opb[i] = 8'h80;
    end
    run_txn(3, 1'b1, 0, 1);

    // Reset after 2 of 4 beats discards the partial sum
    start = 1'b1; len = 8'd4; signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a        = 8'($urandom_range(1, 255));
      b        = 8'($urandom_range(1, 255));
      @(posedge clk); #1;
    end
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check_zero("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    opa[0] = 8'd3;
    opb[0] = 8'd4;
    run_txn(1, 1'b0, 0, 0);

    // Randomised transactions
    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        opa[i] = 8'($urandom);
        opb[i] = 8'($urandom);
      end
      run_txn(n, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
